// File: rtl/span_cmd_writer_pkg.sv
// Shared definitions for the span command writer and the command-queue reader:
// frame geometry, command word field positions, FSM encoding and word builders.
package span_cmd_writer_pkg;

    localparam int SCW_LINES    = 120;
    localparam int SCW_WIDTH    = 160;

    localparam int W0_LINE_LSB  = 8;
    localparam int W0_LEFT_LSB  = 0;
    localparam int W1_COLOR_LSB = 13;
    localparam int W1_RIGHT_LSB = 0;

    localparam int REQ_BITS     = 26;

    typedef enum logic [2:0] {
        IDLE,
        SPAN_W0,
        SPAN_W1,
        CLR_W0,
        CLR_W1
    } state_t;

    typedef struct packed {
        logic [2:0] color;
        logic [6:0] line;
        logic [7:0] left;
        logic [7:0] right;
    } span_req_t;

    function automatic logic [15:0] make_w0(input logic [6:0] line, input logic [7:0] left);
        logic [15:0] w;
        w = '0;
        w[W0_LINE_LSB +: 7] = line;
        w[W0_LEFT_LSB +: 8] = left;
        return w;
    endfunction

    function automatic logic [15:0] make_w1(input logic [2:0] color, input logic [7:0] right);
        logic [15:0] w;
        w = '0;
        w[W1_COLOR_LSB +: 3] = color;
        w[W1_RIGHT_LSB +: 8] = right;
        return w;
    endfunction

endpackage

// File: rtl/span_cmd_writer_fifo.sv
// Request FIFO holding normalised span requests; pointers carry one extra
// wrap bit so full and empty are distinguishable.
module span_req_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 26
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_push;
    logic          w_pop;

    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/span_cmd_writer.sv
// Turns span requests and full-screen clear pulses into two-word commands for
// a downstream command queue, honouring its full backpressure.
module span_cmd_writer
    import span_cmd_writer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LINES = SCW_LINES,
    parameter int WIDTH = SCW_WIDTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_line,
    input  logic [7:0]  req_left,
    input  logic [7:0]  req_right,
    input  logic [2:0]  req_color,
    input  logic        clear_req,
    input  logic [2:0]  clear_color,
    output logic        we,
    output logic [15:0] data,
    input  logic        full,
    output logic        busy,
    output logic        err_drop
);

    localparam logic [6:0] LAST_LINE = 7'(LINES - 1);
    localparam logic [7:0] MAX_X     = 8'(WIDTH - 1);

    state_t      r_state;
    logic [15:0] r_data;
    logic        r_we;
    logic        r_err;
    logic        r_clr_pend;
    logic [2:0]  r_clr_color;
    logic [2:0]  r_fill_color;
    logic [6:0]  r_line_cnt;
    span_req_t   r_cur;

    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_in_clear;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic        w_write;
    logic [7:0]  w_lo;
    logic [7:0]  w_hi;
    span_req_t   w_req;
    span_req_t   w_head;

    assign w_in_clear = (r_state == CLR_W0) || (r_state == CLR_W1);
    assign req_ready  = !w_fifo_full && !w_in_clear;
    assign w_accept   = req_valid && req_ready;
    assign w_push     = w_accept && (req_line <= LAST_LINE);
    assign w_pop      = (r_state == IDLE) && !r_clr_pend && !w_fifo_empty;
    // A word only moves when the queue has room, so we is masked by full.
    assign w_write    = r_we && !full;

    assign we       = w_write;
    assign data     = r_data;
    assign err_drop = r_err;
    assign busy     = !w_fifo_empty || (r_state != IDLE) || r_clr_pend;

    always_comb begin
        w_lo = (req_left > req_right) ? req_right : req_left;
        w_hi = (req_left > req_right) ? req_left  : req_right;
        if (w_lo > MAX_X) w_lo = MAX_X;
        if (w_hi > MAX_X) w_hi = MAX_X;
        w_req       = '0;
        w_req.color = req_color;
        w_req.line  = req_line;
        w_req.left  = w_lo;
        w_req.right = w_hi;
    end

    span_req_fifo #(
        .DEPTH (DEPTH),
        .DW    (REQ_BITS)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (w_req),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_data       <= '0;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_clr_pend   <= 1'b0;
            r_clr_color  <= '0;
            r_fill_color <= '0;
            r_line_cnt   <= '0;
            r_cur        <= '0;
        end else begin
            r_err <= w_accept && (req_line > LAST_LINE);
            case (r_state)
                IDLE: begin
                    if (r_clr_pend) begin
                        r_clr_pend   <= 1'b0;
                        r_fill_color <= r_clr_color;
                        r_line_cnt   <= '0;
                        r_data       <= make_w0(7'd0, 8'd0);
                        r_we         <= 1'b1;
                        r_state      <= CLR_W0;
                    end else if (!w_fifo_empty) begin
                        r_cur   <= w_head;
                        r_data  <= make_w0(w_head.line, w_head.left);
                        r_we    <= 1'b1;
                        r_state <= SPAN_W0;
                    end
                end
                SPAN_W0: if (w_write) begin
                    r_data  <= make_w1(r_cur.color, r_cur.right);
                    r_state <= SPAN_W1;
                end
                SPAN_W1: if (w_write) begin
                    r_we    <= 1'b0;
                    r_state <= IDLE;
                end
                CLR_W0: if (w_write) begin
                    r_data  <= make_w1(r_fill_color, MAX_X);
                    r_state <= CLR_W1;
                end
                CLR_W1: if (w_write) begin
                    if (r_line_cnt == LAST_LINE) begin
                        r_we       <= 1'b0;
                        r_line_cnt <= '0;
                        r_state    <= IDLE;
                    end else begin
                        r_line_cnt <= r_line_cnt + 7'd1;
                        r_data     <= make_w0(r_line_cnt + 7'd1, 8'd0);
                        r_state    <= CLR_W0;
                    end
                end
                default: r_state <= IDLE;
            endcase
            // Placed after the case so a pulse coinciding with the start of a clear re-arms.
            if (clear_req && !w_in_clear) begin
                r_clr_pend  <= 1'b1;
                r_clr_color <= clear_color;
            end
        end
    end

endmodule

// File: tb/tb_span_cmd_writer.sv
// Scoreboard bench for span_cmd_writer: expected command words are queued as
// stimulus is driven and matched against the words the queue actually accepts.
module tb_span_cmd_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_line = '0;
    logic [7:0]  req_left = '0;
    logic [7:0]  req_right = '0;
    logic [2:0]  req_color = '0;
    logic        clear_req = 1'b0;
    logic [2:0]  clear_color = '0;
    logic        we;
    logic [15:0] data;
    logic        full = 1'b0;
    logic        busy;
    logic        err_drop;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [15:0] obs_data [1024];
    int          obs_edge [1024];
    int          obs_wr = 0;
    int          obs_rd = 0;
    logic [15:0] exp_q [$];

    span_cmd_writer #(
        .DEPTH (4),
        .LINES (120),
        .WIDTH (160)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_line    (req_line),
        .req_left    (req_left),
        .req_right   (req_right),
        .req_color   (req_color),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .we          (we),
        .data        (data),
        .full        (full),
        .busy        (busy),
        .err_drop    (err_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record each word that will be taken on the coming rising edge.
    always @(negedge clk) begin
        if (reset && we && !full && obs_wr < 1024) begin
            obs_data[obs_wr] <= data;
            obs_edge[obs_wr] <= cyc + 1;
            obs_wr           <= obs_wr + 1;
        end
    end

    task automatic send(input logic [6:0] l, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] c, output int acc);
        req_valid = 1'b1; req_line = l; req_left = a; req_right = b; req_color = c;
        for (int i = 0; i < 50 && !req_ready; i++) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_obs(input int target, input int budget, output bit ok);
        for (int i = 0; i < budget && obs_wr < target; i++) begin @(posedge clk); #1; end
        ok = (obs_wr >= target);
    endtask

    task automatic test_reset();
        #3;
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", we); end
        checks++; if (data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_drop); end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_single_span();
        int acc, base; bit ok; logic [15:0] e;
        base = obs_wr;
        send(7'd5, 8'd10, 8'd20, 3'b101, acc);
        exp_q.push_back(16'h050A);
        exp_q.push_back(16'hA014);
        wait_obs(base + 2, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got %0d words expected 2", obs_wr - base); end
        while (exp_q.size() > 0 && obs_rd < obs_wr) begin
            e = exp_q.pop_front(); checks++;
            if (obs_data[obs_rd] !== e) begin errors++; $display("FAIL single_word[%0d]: got %h expected %h", obs_rd, obs_data[obs_rd], e); end
            obs_rd++;
        end
        exp_q.delete();
        checks++; if (obs_edge[base] !== acc + 2) begin errors++; $display("FAIL latency_w0: got edge %0d expected %0d", obs_edge[base], acc + 2); end
        checks++; if (obs_edge[base+1] !== acc + 3) begin errors++; $display("FAIL latency_w1: got edge %0d expected %0d", obs_edge[base+1], acc + 3); end
    endtask

    task automatic test_normalise();
        int acc, base; bit ok; logic [15:0] e;
        base = obs_wr;
        send(7'd7, 8'd90, 8'd30, 3'b011, acc);
        send(7'd1, 8'd10, 8'd200, 3'b000, acc);
        send(7'd2, 8'd250, 8'd170, 3'b111, acc);
        exp_q.push_back(16'h071E); exp_q.push_back(16'h605A);
        exp_q.push_back(16'h010A); exp_q.push_back(16'h009F);
        exp_q.push_back(16'h029F); exp_q.push_back(16'hE09F);
        wait_obs(base + 6, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL norm_timeout: got %0d words expected 6", obs_wr - base); end
        while (exp_q.size() > 0 && obs_rd < obs_wr) begin
            e = exp_q.pop_front(); checks++;
            if (obs_data[obs_rd] !== e) begin errors++; $display("FAIL norm_word[%0d]: got %h expected %h", obs_rd, obs_data[obs_rd], e); end
            obs_rd++;
        end
        exp_q.delete();
    endtask

    task automatic test_drop();
        int acc, base, pulses; bit ok, bz; logic [15:0] e;
        base = obs_wr; pulses = 0; bz = 0;
        send(7'd120, 8'd1, 8'd2, 3'b011, acc);
        for (int i = 0; i < 8; i++) begin
            if (err_drop) pulses++;
            if (busy) bz = 1;
            @(posedge clk); #1;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL drop_pulse: got %0d pulses expected 1", pulses); end
        checks++; if (obs_wr != base) begin errors++; $display("FAIL drop_writes: got %0d words expected 0", obs_wr - base); end
        checks++; if (bz) begin errors++; $display("FAIL drop_busy: got 1 expected 0"); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL drop_ready: got %b expected 1", req_ready); end
        send(7'd119, 8'd0, 8'd159, 3'b001, acc);
        exp_q.push_back(16'h7700); exp_q.push_back(16'h209F);
        wait_obs(base + 2, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL lastline_timeout: got %0d words expected 2", obs_wr - base); end
        checks++; if (err_drop !== 1'b0) begin errors++; $display("FAIL lastline_err: got %b expected 0", err_drop); end
        while (exp_q.size() > 0 && obs_rd < obs_wr) begin
            e = exp_q.pop_front(); checks++;
            if (obs_data[obs_rd] !== e) begin errors++; $display("FAIL lastline_word[%0d]: got %h expected %h", obs_rd, obs_data[obs_rd], e); end
            obs_rd++;
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        int acc, base; bit ok; logic [15:0] e;
        base = obs_wr;
        full = 1'b1;
        send(7'd3, 8'd4, 8'd5, 3'b110, acc);
        for (int i = 0; i < 10 && data !== 16'h0304; i++) begin @(posedge clk); #1; end
        for (int i = 0; i < 5; i++) begin
            checks++; if (we !== 1'b0) begin errors++; $display("FAIL bp_we[%0d]: got %b expected 0", i, we); end
            checks++; if (data !== 16'h0304) begin errors++; $display("FAIL bp_data[%0d]: got %h expected 0304", i, data); end
            @(posedge clk); #1;
        end
        full = 1'b0;
        exp_q.push_back(16'h0304); exp_q.push_back(16'hC005);
        wait_obs(base + 2, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got %0d words expected 2", obs_wr - base); end
        repeat (5) begin @(posedge clk); #1; end
        checks++; if (obs_wr != base + 2) begin errors++; $display("FAIL bp_count: got %0d words expected 2", obs_wr - base); end
        while (exp_q.size() > 0 && obs_rd < obs_wr) begin
            e = exp_q.pop_front(); checks++;
            if (obs_data[obs_rd] !== e) begin errors++; $display("FAIL bp_word[%0d]: got %h expected %h", obs_rd, obs_data[obs_rd], e); end
            obs_rd++;
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int acc, base; bit ok; logic [15:0] e; logic [6:0] l; logic [7:0] a, b; logic [2:0] c;
        base = obs_wr;
        for (int i = 0; i < 4; i++) begin
            l = 7'(40 + i); a = 8'(i * 3); b = 8'(i * 3 + 7); c = 3'(i + 2);
            send(l, a, b, c, acc);
            exp_q.push_back({1'b0, l, a});
            exp_q.push_back({c, 5'b00000, b});
        end
        wait_obs(base + 8, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got %0d words expected 8", obs_wr - base); end
        checks++; if (obs_edge[base+2] - obs_edge[base] != 3) begin errors++; $display("FAIL b2b_span_gap: got %0d expected 3", obs_edge[base+2] - obs_edge[base]); end
        checks++; if (obs_edge[base+3] - obs_edge[base+2] != 1) begin errors++; $display("FAIL b2b_word_gap: got %0d expected 1", obs_edge[base+3] - obs_edge[base+2]); end
        while (exp_q.size() > 0 && obs_rd < obs_wr) begin
            e = exp_q.pop_front(); checks++;
            if (obs_data[obs_rd] !== e) begin errors++; $display("FAIL b2b_word[%0d]: got %h expected %h", obs_rd, obs_data[obs_rd], e); end
            obs_rd++;
        end
        exp_q.delete();
    endtask

    task automatic test_clear_mid_span();
        int acc, base; bit ok; logic [15:0] e; logic [6:0] lv;
        base = obs_wr;
        send(7'd20, 8'd1, 8'd2, 3'b001, acc);
        send(7'd21, 8'd5, 8'd6, 3'b100, acc);
        clear_req = 1'b1; clear_color = 3'b010;
        @(posedge clk); #1;
        clear_req = 1'b0; clear_color = 3'b000;
        exp_q.push_back(16'h1401); exp_q.push_back(16'h2002);
        for (int i = 0; i < 120; i++) begin
            lv = 7'(i);
            exp_q.push_back({1'b0, lv, 8'h00});
            exp_q.push_back(16'h409F);
        end
        exp_q.push_back(16'h1505); exp_q.push_back(16'h8006);
        wait_obs(base + 50, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clr_mid_timeout: got %0d words expected 50", obs_wr - base); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL clr_ready: got %b expected 0", req_ready); end
        clear_req = 1'b1; clear_color = 3'b111;
        @(posedge clk); #1;
        clear_req = 1'b0; clear_color = 3'b000;
        wait_obs(base + 244, 600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clr_timeout: got %0d words expected 244", obs_wr - base); end
        repeat (10) begin @(posedge clk); #1; end
        checks++; if (obs_wr != base + 244) begin errors++; $display("FAIL clr_count: got %0d words expected 244", obs_wr - base); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy_end: got %b expected 0", busy); end
        while (exp_q.size() > 0 && obs_rd < obs_wr) begin
            e = exp_q.pop_front(); checks++;
            if (obs_data[obs_rd] !== e) begin errors++; $display("FAIL clr_word[%0d]: got %h expected %h", obs_rd, obs_data[obs_rd], e); end
            obs_rd++;
        end
        exp_q.delete();
        obs_rd = obs_wr;
    endtask

    task automatic test_clear_busy();
        int base; logic prev_busy;
        base = obs_wr; prev_busy = 1'b0;
        clear_req = 1'b1; clear_color = 3'b010;
        @(posedge clk); #1;
        clear_req = 1'b0; clear_color = 3'b000;
        for (int i = 0; i < 600 && obs_wr < base + 240; i++) begin
            prev_busy = busy;
            @(posedge clk); #1;
        end
        checks++; if (obs_wr != base + 240) begin errors++; $display("FAIL clrb_timeout: got %0d words expected 240", obs_wr - base); end
        checks++; if (prev_busy !== 1'b1) begin errors++; $display("FAIL clrb_busy_before: got %b expected 1", prev_busy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clrb_busy_after: got %b expected 0", busy); end
        checks++; if (obs_data[base+238] !== 16'h7700) begin errors++; $display("FAIL clrb_last_w0: got %h expected 7700", obs_data[base+238]); end
        checks++; if (obs_data[base+239] !== 16'h409F) begin errors++; $display("FAIL clrb_last_w1: got %h expected 409F", obs_data[base+239]); end
        repeat (5) begin @(posedge clk); #1; end
        checks++; if (obs_wr != base + 240) begin errors++; $display("FAIL clrb_count: got %0d words expected 240", obs_wr - base); end
        obs_rd = obs_wr;
    endtask

    task automatic test_reset_mid_span();
        int acc, base; logic [15:0] e;
        base = obs_wr;
        full = 1'b1;
        for (int i = 0; i < 4; i++) send(7'(30 + i), 8'(i), 8'(40 + i), 3'(i + 1), acc);
        exp_q.push_back(16'h1E00);
        full = 1'b0;
        for (int i = 0; i < 10 && data !== 16'h2028; i++) begin @(posedge clk); #1; end
        checks++; if (data !== 16'h2028) begin errors++; $display("FAIL rst_mid_w1: got %h expected 2028", data); end
        reset = 1'b0;
        #1;
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL rst_mid_we: got %b expected 0", we); end
        checks++; if (data !== 16'h0000) begin errors++; $display("FAIL rst_mid_data: got %h expected 0000", data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        checks++; if (obs_wr != base + 1) begin errors++; $display("FAIL rst_mid_count: got %0d words expected 1", obs_wr - base); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy_after: got %b expected 0", busy); end
        while (exp_q.size() > 0 && obs_rd < obs_wr) begin
            e = exp_q.pop_front(); checks++;
            if (obs_data[obs_rd] !== e) begin errors++; $display("FAIL rst_mid_word[%0d]: got %h expected %h", obs_rd, obs_data[obs_rd], e); end
            obs_rd++;
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_span();
        test_normalise();
        test_drop();
        test_backpressure();
        test_back_to_back();
        test_clear_mid_span();
        test_clear_busy();
        test_reset_mid_span();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/span_cmd_writer.md
SPAN_CMD_WRITER -- requirements
Module: span_cmd_writer

Interface
REQ-001 Parameter DEPTH, default 4, request FIFO entries (power of 2, >=2).
REQ-002 Parameter LINES, default 120, frame height in lines.
REQ-003 Parameter WIDTH, default 160, frame width in pixels.
REQ-004 Port clk, input, 1, single clock for all logic.
REQ-005 Port reset, input, 1, asynchronous, active-low reset.
REQ-006 Port req_valid, input, 1, span request present.
REQ-007 Port req_ready, output, 1, FIFO can accept a request this cycle.
REQ-008 Port req_line, input, 7, target line.
REQ-009 Port req_left, input, 8, first pixel.
REQ-010 Port req_right, input, 8, last pixel.
REQ-011 Port req_color, input, 3, {R,G,B}.
REQ-012 Port clear_req, input, 1, one-cycle pulse requesting a full-screen fill.
REQ-013 Port clear_color, input, 3, fill colour, sampled with clear_req.
REQ-014 Port we, output, 1, command-queue write strobe.
REQ-015 Port data, output, 16, command word.
REQ-016 Port full, input, 1, command queue full (backpressure).
REQ-017 Port busy, output, 1, FIFO non-empty, word emission pending, or clear in progress.
REQ-018 Port err_drop, output, 1, one-cycle pulse: request dropped for req_line >= LINES.

Function
REQ-019 Each span SHALL be emitted as two words, in order: W0 = {1'b0, line[6:0], left[7:0]}, W1 = {color[2:0], 5'b0, right[7:0]}.
REQ-020 Handshake in: request accepted on a clk edge with req_valid && req_ready; req_ready = FIFO not full and no clear in progress.
REQ-021 Handshake out: a word counts as written only on an edge where we=1 and full=0; we SHALL be driven 0 whenever full=1.
REQ-022 If full rises while a word is pending, data SHALL hold its value and the word SHALL be re-offered once full falls; no word is lost or duplicated.
REQ-023 Normalisation on acceptance: left > right -> swap; any value > WIDTH-1 -> clamp to WIDTH-1.
REQ-024 req_line >= LINES -> not written to FIFO, err_drop pulses for 1 cycle, req_ready unaffected.
REQ-025 FSM states: IDLE, SPAN_W0, SPAN_W1, CLR_W0, CLR_W1.
REQ-026 IDLE -> CLR_W0 when a clear is pending; else -> SPAN_W0 when FIFO non-empty (entry popped on this transition).
REQ-027 SPAN_W0 -> SPAN_W1 on W0 written; SPAN_W1 -> IDLE on W1 written.
REQ-028 Clear: line counter 0..LINES-1, each line emits span left=0, right=WIDTH-1, colour clear_color; CLR_W1 -> CLR_W0 (counter+1) on W1 written, -> IDLE after line LINES-1.
REQ-029 clear_req arriving mid-span SHALL be latched and serviced after the current span's W1; clear_req during a clear SHALL be ignored.
REQ-030 Clear SHALL take priority over queued FIFO entries; queued spans follow the clear in original order.
REQ-031 Minimum latency: request accepted at edge N with FIFO empty, IDLE, full=0 -> W0 written at edge N+2, W1 at edge N+3.
REQ-032 Sustained throughput with full=0: one word per cycle plus one IDLE cycle per span.
REQ-033 Simultaneous push and pop on a full FIFO is not possible (req_ready low); on a non-full FIFO both SHALL occur in the same cycle.
REQ-034 FIFO pointers SHALL wrap modulo DEPTH with an extra bit distinguishing full from empty.

Reset
REQ-035 reset=0 SHALL immediately force: state IDLE, FIFO empty, clear-pending 0, line counter 0, we=0, data=0, err_drop=0, busy=0; req_ready=1 once reset is deasserted.
REQ-036 Reset asserted mid-span or mid-clear SHALL abandon the operation; no partial span is re-issued after release.

Structure
REQ-037 Shared package SHALL hold LINES, WIDTH, the W0/W1 field positions and the FSM state encoding, for reuse by the queue reader.
REQ-038 One sub-module, span_req_fifo (DEPTH x 26-bit, synchronous, same clk/reset), SHALL hold normalised requests.

Verification
REQ-039 Single span line=5, left=10, right=20, colour 3'b101, full=0 -> data 16'h050A then 16'hA014 on consecutive edges.
REQ-040 left=90, right=30 -> W0 low byte 8'h1E, W1 low byte 8'h5A; right=200 -> clamped to 8'h9F.
REQ-041 req_line=120 -> err_drop pulses once, no we asserted, busy stays 0.
REQ-042 full held 1 for 5 cycles after W0 is offered -> we=0 and data stable throughout, W0 written exactly once after release.
REQ-043 clear_req with colour 3'b010 -> exactly 240 writes, last pair 16'h7700 / 16'h409F; busy falls the cycle after the final write.
REQ-044 Fill FIFO with 4 spans, then reset=0 mid-W1 -> we=0 immediately, no further writes after release, req_ready=1.
